// File: rtl/hls_exec_activity_monitor.sv
// Passive activity monitor for an HLS-generated accelerator.
// Observes one module handshake (ap_*) and one pipelined loop (FSM state
// compares plus loop_* handshake). Produces registered event flags with a
// cycle stamp and saturating counters. Everything freezes once finish is seen.
module hls_exec_activity_monitor #(
  parameter int STATE_W = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic               frozen,
  output logic               mod_busy,
  output logic               loop_active,
  output logic [5:0]         ev_vec,
  output logic [CNT_W-1:0]   ev_time,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   mod_starts,
  output logic [CNT_W-1:0]   mod_dones,
  output logic [CNT_W-1:0]   mod_busy_cycles,
  output logic [CNT_W-1:0]   loop_invocs,
  output logic [CNT_W-1:0]   iters_started,
  output logic [CNT_W-1:0]   iters_ended,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   loop_quits
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } mod_state_e;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  mod_state_e       mod_state_q, mod_state_d;
  logic             frozen_q;
  logic             loop_active_q, loop_active_d;
  logic [5:0]       ev_vec_q, ev_d;
  logic [CNT_W-1:0] ev_time_q;
  logic [CNT_W-1:0] cycle_cnt_q, mod_starts_q, mod_dones_q, mod_busy_cycles_q;
  logic [CNT_W-1:0] loop_invocs_q, iters_started_q, iters_ended_q;
  logic [CNT_W-1:0] stall_cycles_q, loop_quits_q;

  logic mod_start_ev, mod_done_ev;
  logic istart_c, iend_c, quit_raw, stall_ev;
  logic quit_ev, loop_start_ev, istart_ev, iend_ev, in_loop;

  // loop_ready is part of the observed handshake but carries no event.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, loop_ready};

  // Module handshake FSM: next state plus start/done strobes.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mod_state_d  = mod_state_q;
    mod_start_ev = 1'b0;
    mod_done_ev  = 1'b0;
    case (mod_state_q)
      S_IDLE: begin
        if (ap_start) begin
          mod_state_d  = S_BUSY;
          mod_start_ev = 1'b1;
        end
      end
      S_BUSY: begin
        if (ap_done && ap_continue) begin
          mod_done_ev = 1'b1;
          if (ap_start) mod_start_ev = 1'b1;   // back-to-back: stay busy
          else          mod_state_d  = S_IDLE;
        end else if (ap_done) begin
          mod_state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ap_continue) begin
          mod_done_ev = 1'b1;
          mod_state_d = S_IDLE;
        end
      end
      default: mod_state_d = S_IDLE;
    endcase
  end

  // Loop conditions, loop-active flag and the event vector to register.
  always_comb begin
    istart_c = (cur_state == iter_start_state) && !iter_start_block && iter_start_enable;
    iend_c   = (cur_state == iter_end_state) && !iter_end_block && iter_end_enable;
    quit_raw = quit_at_end ? (loop_done && loop_continue)
                           : ((cur_state == quit_state) && !quit_block && quit_enable);
    stall_ev = loop_active_q && (cur_state == iter_start_state) && iter_start_block;

    // A quit only means something for a running loop; a start while active
    // is a new invocation only when the current one quits in the same cycle.
    quit_ev       = loop_active_q && quit_raw;
    loop_start_ev = loop_start && (!loop_active_q || quit_ev);
    loop_active_d = loop_active_q;
    if (loop_start_ev) loop_active_d = 1'b1;
    else if (quit_ev)  loop_active_d = 1'b0;

    in_loop   = loop_active_q || loop_start;
    istart_ev = in_loop && istart_c;
    iend_ev   = in_loop && iend_c;

    ev_d = {iend_ev, quit_ev, loop_start_ev, mod_done_ev, ap_ready, mod_start_ev};
  end

  // Monitor state: frozen flag, FSM, loop flag, events and counters.
  // NOTE: asynchronous reset clears everything at once, even mid-run; all
  // state here is plain flops so every register can be reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frozen_q          <= 1'b0;
      mod_state_q       <= S_IDLE;
      loop_active_q     <= 1'b0;
      ev_vec_q          <= '0;
      ev_time_q         <= '0;
      cycle_cnt_q       <= '0;
      mod_starts_q      <= '0;
      mod_dones_q       <= '0;
      mod_busy_cycles_q <= '0;
      loop_invocs_q     <= '0;
      iters_started_q   <= '0;
      iters_ended_q     <= '0;
      stall_cycles_q    <= '0;
      loop_quits_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      frozen_q <= frozen_q || finish;
      if (frozen_q) begin
        ev_vec_q <= '0;
      end else begin
        mod_state_q       <= mod_state_d;
        loop_active_q     <= loop_active_d;
        ev_vec_q          <= ev_d;
        if (|ev_d) ev_time_q <= cycle_cnt_q;
        cycle_cnt_q       <= sat_inc(cycle_cnt_q, 1'b1);
        mod_starts_q      <= sat_inc(mod_starts_q, mod_start_ev);
        mod_dones_q       <= sat_inc(mod_dones_q, mod_done_ev);
        mod_busy_cycles_q <= sat_inc(mod_busy_cycles_q, mod_state_q != S_IDLE);
        loop_invocs_q     <= sat_inc(loop_invocs_q, loop_start_ev);
        iters_started_q   <= sat_inc(iters_started_q, istart_ev);
        iters_ended_q     <= sat_inc(iters_ended_q, iend_ev);
        stall_cycles_q    <= sat_inc(stall_cycles_q, stall_ev);
        loop_quits_q      <= sat_inc(loop_quits_q, quit_ev);
      end
    end
  end

  assign frozen          = frozen_q;
  assign mod_busy        = (mod_state_q != S_IDLE);
  assign loop_active     = loop_active_q;
  assign ev_vec          = frozen_q ? 6'b0 : ev_vec_q;
  assign ev_time         = ev_time_q;
  assign cycle_cnt       = cycle_cnt_q;
  assign mod_starts      = mod_starts_q;
  assign mod_dones       = mod_dones_q;
  assign mod_busy_cycles = mod_busy_cycles_q;
  assign loop_invocs     = loop_invocs_q;
  assign iters_started   = iters_started_q;
  assign iters_ended     = iters_ended_q;
  assign stall_cycles    = stall_cycles_q;
  assign loop_quits      = loop_quits_q;

endmodule

// File: tb/tb_hls_exec_activity_monitor.sv
// Directed bench for hls_exec_activity_monitor. A second instance with
// 3-bit counters shares the stimulus to exercise saturation.
module tb_hls_exec_activity_monitor;

  localparam int CW = 32;

  logic clock = 1'b0;
  logic reset, finish, ap_start, ap_ready, ap_done, ap_continue;
  logic [0:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic iter_start_block, iter_end_block, quit_block;
  logic iter_start_enable, iter_end_enable, quit_enable;
  logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;

  logic          frozen, mod_busy, loop_active;
  logic [5:0]    ev_vec;
  logic [CW-1:0] ev_time, cycle_cnt, mod_starts, mod_dones, mod_busy_cycles;
  logic [CW-1:0] loop_invocs, iters_started, iters_ended, stall_cycles, loop_quits;

  logic       s_frozen, s_mod_busy, s_loop_active;
  logic [5:0] s_ev_vec;
  logic [2:0] s_ev_time, s_cycle_cnt, s_mod_starts, s_mod_dones, s_mod_busy_cycles;
  logic [2:0] s_loop_invocs, s_iters_started, s_iters_ended, s_stall_cycles, s_loop_quits;

  hls_exec_activity_monitor #(.STATE_W(1), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready),
    .loop_done(loop_done), .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .frozen(frozen), .mod_busy(mod_busy), .loop_active(loop_active),
    .ev_vec(ev_vec), .ev_time(ev_time), .cycle_cnt(cycle_cnt),
    .mod_starts(mod_starts), .mod_dones(mod_dones), .mod_busy_cycles(mod_busy_cycles),
    .loop_invocs(loop_invocs), .iters_started(iters_started), .iters_ended(iters_ended),
    .stall_cycles(stall_cycles), .loop_quits(loop_quits)
  );

  hls_exec_activity_monitor #(.STATE_W(1), .CNT_W(3)) dut_sat (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready),
    .loop_done(loop_done), .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .frozen(s_frozen), .mod_busy(s_mod_busy), .loop_active(s_loop_active),
    .ev_vec(s_ev_vec), .ev_time(s_ev_time), .cycle_cnt(s_cycle_cnt),
    .mod_starts(s_mod_starts), .mod_dones(s_mod_dones), .mod_busy_cycles(s_mod_busy_cycles),
    .loop_invocs(s_loop_invocs), .iters_started(s_iters_started), .iters_ended(s_iters_ended),
    .stall_cycles(s_stall_cycles), .loop_quits(s_loop_quits)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // expected cycle_cnt after the most recent edge

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Advance until the next edge samples with cycle_cnt == k.
  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic clear_inputs();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    cur_state = 1'b1; iter_start_state = 1'b1; iter_end_state = 1'b1; quit_state = 1'b0;
    iter_start_block = 0; iter_end_block = 0; quit_block = 0;
    iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0;
    quit_at_end = 1;
  endtask

  // Loop vectors: {loop_start, start_en, start_blk, end_en, end_blk, done&cont}
  logic [5:0] loop_vec [13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    loop_vec[0] = 6'b110000;
    for (int i = 1; i <= 4; i++)  loop_vec[i] = 6'b010100;
    for (int i = 5; i <= 6; i++)  loop_vec[i] = 6'b011110;
    for (int i = 7; i <= 11; i++) loop_vec[i] = 6'b010100;
    loop_vec[12] = 6'b000101;

    clear_inputs();
    finish = 0;
    reset  = 1;
    #12;
    check("rst_frozen", frozen, 0);
    check("rst_busy", mod_busy, 0);
    check("rst_loop_active", loop_active, 0);
    check("rst_ev_vec", ev_vec, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_mod_starts", mod_starts, 0);
    reset = 0;
    cyc   = 0;
    tick();
    check("first_cycle_cnt", cycle_cnt, 1);

    // Module start at cycle 5, done with continue at cycle 12.
    run_to(5);
    ap_start = 1; tick(); ap_start = 0;
    check("start_ev_vec", ev_vec, 6'h01);
    check("start_ev_time", ev_time, 5);
    check("start_busy", mod_busy, 1);
    check("start_count", mod_starts, 1);
    run_to(12);
    ap_done = 1; ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
    check("done_ev_vec", ev_vec, 6'h04);
    check("done_ev_time", ev_time, 12);
    check("done_count", mod_dones, 1);
    check("busy_cycles_7", mod_busy_cycles, 7);
    check("done_idle", mod_busy, 0);
    check("cycle_cnt_13", cycle_cnt, 13);
    check("sat_cycle_cnt", s_cycle_cnt, 7);
    check("sat_busy_7", s_mod_busy_cycles, 7);
    tick();
    check("ev_vec_pulse", ev_vec, 0);
    check("ev_time_hold", ev_time, 12);

    // Done without continue: HOLD for 3 cycles, counted on the continue cycle.
    run_to(14);
    ap_start = 1; tick(); ap_start = 0;
    run_to(16);
    ap_done = 1; ap_continue = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_no_done", mod_dones, 1);
      check("hold_busy", mod_busy, 1);
    end
    ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
    check("hold_done_count", mod_dones, 2);
    check("hold_done_ev", ev_vec, 6'h04);
    check("hold_done_time", ev_time, 19);
    check("hold_idle", mod_busy, 0);
    check("hold_busy_cycles", mod_busy_cycles, 12);
    check("sat_busy_hold", s_mod_busy_cycles, 7);

    // ap_ready event and back-to-back done+start.
    run_to(21);
    ap_start = 1; tick(); ap_start = 0;
    ap_ready = 1; tick(); ap_ready = 0;
    check("ready_ev", ev_vec, 6'h02);
    check("ready_time", ev_time, 22);
    ap_done = 1; ap_continue = 1; ap_start = 1; tick(); ap_start = 0;
    check("b2b_ev", ev_vec, 6'h05);
    check("b2b_starts", mod_starts, 4);
    check("b2b_dones", mod_dones, 3);
    check("b2b_busy", mod_busy, 1);
    tick(); ap_done = 0; ap_continue = 0;
    check("b2b_end_dones", mod_dones, 4);
    check("b2b_end_idle", mod_busy, 0);
    check("b2b_busy_cycles", mod_busy_cycles, 15);

    // Loop of 10 iterations with a 2-cycle stall, quit on loop_done.
    run_to(26);
    for (int i = 0; i < 13; i++) begin
      loop_start        = loop_vec[i][5];
      iter_start_enable = loop_vec[i][4];
      iter_start_block  = loop_vec[i][3];
      iter_end_enable   = loop_vec[i][2];
      iter_end_block    = loop_vec[i][1];
      loop_done         = loop_vec[i][0];
      loop_continue     = loop_vec[i][0];
      tick();
      if (i == 0) begin
        check("loop_start_active", loop_active, 1);
        check("loop_start_ev", ev_vec, 6'h08);
        check("loop_start_time", ev_time, 26);
      end
    end
    clear_inputs();
    check("loop_iters_started", iters_started, 10);
    check("loop_iters_ended", iters_ended, 10);
    check("loop_stalls", stall_cycles, 2);
    check("loop_invocs", loop_invocs, 1);
    check("loop_quits", loop_quits, 1);
    check("loop_inactive", loop_active, 0);
    check("loop_quit_iend_ev", ev_vec, 6'h30);
    check("loop_quit_time", ev_time, 38);
    check("sat_iters", s_iters_started, 7);

    // Quit via the quit-state condition at cycle 40; later loop_done ignored.
    loop_start = 1; tick(); loop_start = 0;
    check("q0_active", loop_active, 1);
    check("q0_invocs", loop_invocs, 2);
    quit_at_end = 0; quit_state = 1'b1; quit_enable = 1; tick(); quit_enable = 0;
    check("q0_cleared", loop_active, 0);
    check("q0_quits", loop_quits, 2);
    check("q0_ev", ev_vec, 6'h10);
    check("q0_time", ev_time, 40);
    check("q0_cycle", cycle_cnt, 41);
    loop_done = 1; loop_continue = 1; tick(); loop_done = 0; loop_continue = 0;
    check("q0_done_ignored", loop_quits, 2);
    check("q0_done_no_ev", ev_vec, 0);
    clear_inputs();

    // Freeze mid-loop.
    loop_start = 1; iter_start_enable = 1; tick(); loop_start = 0;
    tick(); tick();
    check("pre_freeze_iters", iters_started, 13);
    iter_start_enable = 0; finish = 1; tick(); finish = 0;
    check("frozen_set", frozen, 1);
    check("freeze_cycle", cycle_cnt, 46);
    ap_start = 1; ap_ready = 1; iter_start_enable = 1; iter_end_enable = 1;
    loop_done = 1; loop_continue = 1;
    for (int i = 0; i < 4; i++) tick();
    check("frozen_hold", frozen, 1);
    check("frozen_cycle", cycle_cnt, 46);
    check("frozen_starts", mod_starts, 4);
    check("frozen_iters", iters_started, 13);
    check("frozen_iends", iters_ended, 10);
    check("frozen_quits", loop_quits, 2);
    check("frozen_ev_vec", ev_vec, 0);
    check("frozen_ev_time", ev_time, 42);
    check("frozen_loop_active", loop_active, 1);
    check("frozen_busy", mod_busy, 0);

    // Asynchronous reset mid-run.
    #2 reset = 1;
    #1;
    check("mid_rst_cycle", cycle_cnt, 0);
    check("mid_rst_frozen", frozen, 0);
    check("mid_rst_starts", mod_starts, 0);
    check("mid_rst_iters", iters_started, 0);
    check("mid_rst_loop_active", loop_active, 0);
    check("mid_rst_ev_time", ev_time, 0);
    check("mid_rst_invocs", loop_invocs, 0);
    clear_inputs();
    @(negedge clock);
    reset = 0;
    cyc   = 0;
    tick();
    check("post_rst_cycle", cycle_cnt, 1);
    check("post_rst_frozen", frozen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
